// File: rtl/exwb_stage_if.sv
// -----------------------------------------------------------------------------
// exwb_stage_if
//   Data-memory request/acknowledge bus between the execute/writeback stage
//   and the data memory. The stage makes one request at a time and holds the
//   address, direction and write data stable until the memory acknowledges
//   or the stage gives up.
//
//   Signals
//     mem_req    stage -> mem   request, held until ack or timeout
//     mem_we     stage -> mem   1 store, 0 load (valid while mem_req)
//     mem_addr   stage -> mem   byte address
//     mem_wdata  stage -> mem   store data
//     mem_rdata  mem -> stage   load data, valid with mem_ack
//     mem_ack    mem -> stage   one-cycle completion
//
//   Modports
//     master  the execute/writeback stage
//     slave   the data memory
// -----------------------------------------------------------------------------
interface exwb_stage_if;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/exwb_stage.sv
// -----------------------------------------------------------------------------
// exwb_stage
//   Execute-to-writeback stage sitting directly after the ALU. Accepts one
//   instruction at a time, resolves BEQ/BNE, performs loads and stores over
//   the data-memory bus (with a timeout), and issues one-cycle register-file
//   write pulses. This block is the only writer of the register file.
//
//   Parameters
//     RF_ADDR_W    register-file address width
//     ZERO_REG     1: writes to r0 are dropped (r0 hard-wired zero)
//     MEM_TIMEOUT  cycles mem_req may stay high without mem_ack (1..255)
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     in_valid / in_ready      instruction handshake (ready only in IDLE)
//     opcode, alu_result,      instruction fields and ALU outputs, captured
//     alu_compare, rd,         on acceptance
//     store_data, branch_target
//     mem_bus                  data-memory bus (exwb_stage_if.master)
//     rf_we/rf_waddr/rf_wdata  register-file write pulse and payload
//     br_taken/br_target       branch-taken pulse and target
//     mem_err                  one-cycle pulse when a memory access times out
//
//   Optional feature (macro EXWB_FWD_EN)
//     Adds fwd_valid/fwd_addr/fwd_data: a registered copy of the most recent
//     register-file write, available from the cycle after rf_we, for operand
//     forwarding. With the macro undefined the ports and logic are absent.
//
//   Opcodes
//     0000-0110  ALU op, write alu_result to rd
//     0111       BEQ
//     1000       BNE
//     1001       load  rd <- mem[alu_result]
//     1010       store mem[alu_result] <- store_data
//     others     NOP (one WB cycle, no side effects)
//
//   State | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a new instruction
//   MEM_W | memory request outstanding, waiting for ack or timeout
//   WB    | one-cycle writeback / branch-resolve slot, not ready
// -----------------------------------------------------------------------------
module exwb_stage #(
    parameter int RF_ADDR_W   = 3,
    parameter int ZERO_REG    = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           opcode,
    input  logic [7:0]           alu_result,
    input  logic                 alu_compare,
    input  logic [RF_ADDR_W-1:0] rd,
    input  logic [7:0]           store_data,
    input  logic [7:0]           branch_target,

    exwb_stage_if.master         mem_bus,

    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [7:0]           rf_wdata,
    output logic                 br_taken,
    output logic [7:0]           br_target,
    output logic                 mem_err
`ifdef EXWB_FWD_EN
    ,
    output logic                 fwd_valid,
    output logic [RF_ADDR_W-1:0] fwd_addr,
    output logic [7:0]           fwd_data
`endif
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_WB       = 2'd2;

    localparam logic [3:0] OP_ALU_LAST = 4'b0110;
    localparam logic [3:0] OP_BEQ      = 4'b0111;
    localparam logic [3:0] OP_BNE      = 4'b1000;
    localparam logic [3:0] OP_LOAD     = 4'b1001;
    localparam logic [3:0] OP_STORE    = 4'b1010;

    // Last cycle index of a request: the counter starts at 0 in the first
    // request cycle, so reaching MEM_TIMEOUT-1 without ack means mem_req has
    // been high for exactly MEM_TIMEOUT cycles.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0]           state;
    logic [7:0]           tmo_cnt;
    logic [RF_ADDR_W-1:0] rd_q;

    // A suppressed r0 write keeps the normal WB timing; only the pulse and
    // the write payload update are skipped.
    function automatic logic wr_blocked(input logic [RF_ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    assign in_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            tmo_cnt           <= '0;
            rd_q              <= '0;
            rf_we             <= 1'b0;
            rf_waddr          <= '0;
            rf_wdata          <= '0;
            br_taken          <= 1'b0;
            br_target         <= '0;
            mem_err           <= 1'b0;
            mem_bus.mem_req   <= 1'b0;
            mem_bus.mem_we    <= 1'b0;
            mem_bus.mem_addr  <= '0;
            mem_bus.mem_wdata <= '0;
        end else begin
            // Pulse outputs default low; data outputs hold.
            rf_we    <= 1'b0;
            br_taken <= 1'b0;
            mem_err  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        rd_q <= rd;
                        if (opcode <= OP_ALU_LAST) begin
                            state <= ST_WB;
                            if (!wr_blocked(rd)) begin
                                rf_we    <= 1'b1;
                                rf_waddr <= rd;
                                rf_wdata <= alu_result;
                            end
                        end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                            // ALU already evaluated the condition for the
                            // specific branch kind; alu_compare is the outcome.
                            state    <= ST_WB;
                            br_taken <= alu_compare;
                            if (alu_compare) begin
                                br_target <= branch_target;
                            end
                        end else if (opcode == OP_LOAD) begin
                            state            <= ST_MEM_WAIT;
                            tmo_cnt          <= '0;
                            mem_bus.mem_req  <= 1'b1;
                            mem_bus.mem_we   <= 1'b0;
                            mem_bus.mem_addr <= alu_result;
                        end else if (opcode == OP_STORE) begin
                            state             <= ST_MEM_WAIT;
                            tmo_cnt           <= '0;
                            mem_bus.mem_req   <= 1'b1;
                            mem_bus.mem_we    <= 1'b1;
                            mem_bus.mem_addr  <= alu_result;
                            mem_bus.mem_wdata <= store_data;
                        end else begin
                            state <= ST_WB;
                        end
                    end
                end

                ST_MEM_WAIT: begin
                    // Ack is checked first so an ack on the timeout cycle
                    // completes the access normally.
                    if (mem_bus.mem_ack) begin
                        mem_bus.mem_req <= 1'b0;
                        if (!mem_bus.mem_we) begin
                            state <= ST_WB;
                            if (!wr_blocked(rd_q)) begin
                                rf_we    <= 1'b1;
                                rf_waddr <= rd_q;
                                rf_wdata <= mem_bus.mem_rdata;
                            end
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_bus.mem_req <= 1'b0;
                        mem_err         <= 1'b1;
                        state           <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                ST_WB: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef EXWB_FWD_EN
    // Mirrors the write that was just presented to the register file, so the
    // copy becomes visible the cycle after rf_we and stays until overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else if (rf_we) begin
            fwd_valid <= 1'b1;
            fwd_addr  <= rf_waddr;
            fwd_data  <= rf_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_exwb_stage.sv
module tb_exwb_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [7:0] alu_result;
    logic       alu_compare;
    logic [2:0] rd;
    logic [7:0] store_data;
    logic [7:0] branch_target;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       br_taken;
    logic [7:0] br_target;
    logic       mem_err;
`ifdef EXWB_FWD_EN
    logic       fwd_valid;
    logic [2:0] fwd_addr;
    logic [7:0] fwd_data;
`endif

    exwb_stage_if mem_bus ();

    exwb_stage #(
        .RF_ADDR_W   (3),
        .ZERO_REG    (1),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .alu_result    (alu_result),
        .alu_compare   (alu_compare),
        .rd            (rd),
        .store_data    (store_data),
        .branch_target (branch_target),
        .mem_bus       (mem_bus),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .mem_err       (mem_err)
`ifdef EXWB_FWD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for exactly one accepting edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] res, input logic cmp,
                         input logic [2:0] dst, input logic [7:0] sd, input logic [7:0] bt);
        opcode        = op;
        alu_result    = res;
        alu_compare   = cmp;
        rd            = dst;
        store_data    = sd;
        branch_target = bt;
        in_valid      = 1'b1;
        step();
        in_valid      = 1'b0;
    endtask

    int  req_cycles;
    int  budget;
    logic stable;

    initial begin
        rst               = 1'b1;
        in_valid          = 1'b0;
        opcode            = '0;
        alu_result        = '0;
        alu_compare       = 1'b0;
        rd                = '0;
        store_data        = '0;
        branch_target     = '0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;

        // ---- reset state ----
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_rf_we",    32'(rf_we),    32'd0);
        check("rst_mem_req",  32'(mem_bus.mem_req), 32'd0);
        check("rst_br_taken", 32'(br_taken), 32'd0);
        check("rst_mem_err",  32'(mem_err),  32'd0);
`ifdef EXWB_FWD_EN
        check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
`endif
        rst = 1'b0;
        step();

        // ---- ADD r3 = 0x2A ----
        issue(4'b0000, 8'h2A, 1'b0, 3'd3, 8'h00, 8'h00);
        check("add_rf_we",    32'(rf_we),    32'd1);
        check("add_waddr",    32'(rf_waddr), 32'd3);
        check("add_wdata",    32'(rf_wdata), 32'h2A);
        check("add_ready_lo", 32'(in_ready), 32'd0);
        step();
        check("add_rf_we_end", 32'(rf_we),    32'd0);
        check("add_ready_hi",  32'(in_ready), 32'd1);
        check("add_wdata_hold", 32'(rf_wdata), 32'h2A);

        // ---- op 0110, r7 = 0xC3 ----
        issue(4'b0110, 8'hC3, 1'b0, 3'd7, 8'h00, 8'h00);
        check("alu6_rf_we", 32'(rf_we),    32'd1);
        check("alu6_waddr", 32'(rf_waddr), 32'd7);
        check("alu6_wdata", 32'(rf_wdata), 32'hC3);
        step();

        // ---- BNE taken ----
        issue(4'b1000, 8'h00, 1'b1, 3'd4, 8'h00, 8'h40);
        check("bne_taken",  32'(br_taken),  32'd1);
        check("bne_target", 32'(br_target), 32'h40);
        check("bne_no_wr",  32'(rf_we),     32'd0);
        step();
        check("bne_pulse_end", 32'(br_taken), 32'd0);

        // ---- BNE not taken ----
        issue(4'b1000, 8'h00, 1'b0, 3'd4, 8'h00, 8'h55);
        check("bne_nt_taken", 32'(br_taken), 32'd0);
        check("bne_nt_no_wr", 32'(rf_we),    32'd0);
        check("bne_nt_ready", 32'(in_ready), 32'd0);
        step();

        // ---- BEQ taken ----
        issue(4'b0111, 8'h00, 1'b1, 3'd1, 8'h00, 8'h81);
        check("beq_taken",  32'(br_taken),  32'd1);
        check("beq_target", 32'(br_target), 32'h81);
        step();

        // ---- load r2 <- [0x10], ack in third request cycle ----
        issue(4'b1001, 8'h10, 1'b0, 3'd2, 8'h00, 8'h00);
        check("ld_req_c1",  32'(mem_bus.mem_req),  32'd1);
        check("ld_we",      32'(mem_bus.mem_we),   32'd0);
        check("ld_addr",    32'(mem_bus.mem_addr), 32'h10);
        check("ld_ready",   32'(in_ready),         32'd0);
        step();
        check("ld_req_c2",  32'(mem_bus.mem_req),  32'd1);
        step();
        check("ld_req_c3",  32'(mem_bus.mem_req),  32'd1);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 8'h5A;
        step();
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 8'h00;
        check("ld_req_drop", 32'(mem_bus.mem_req), 32'd0);
        check("ld_rf_we",    32'(rf_we),    32'd1);
        check("ld_waddr",    32'(rf_waddr), 32'd2);
        check("ld_wdata",    32'(rf_wdata), 32'h5A);
        step();
        check("ld_rf_we_end", 32'(rf_we),    32'd0);
        check("ld_ready_hi",  32'(in_ready), 32'd1);

        // ---- stray ack while idle is ignored ----
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 8'hEE;
        step();
        mem_bus.mem_ack   = 1'b0;
        check("stray_ack_req", 32'(mem_bus.mem_req), 32'd0);
        check("stray_ack_we",  32'(rf_we),           32'd0);
        check("stray_ack_rdy", 32'(in_ready),        32'd1);

        // ---- store [0x20] <- 0x77, never acked -> timeout ----
        issue(4'b1010, 8'h20, 1'b0, 3'd6, 8'h77, 8'h00);
        check("st_we",    32'(mem_bus.mem_we),    32'd1);
        check("st_addr",  32'(mem_bus.mem_addr),  32'h20);
        check("st_wdata", 32'(mem_bus.mem_wdata), 32'h77);
        req_cycles = 0;
        budget     = 40;
        stable     = 1'b1;
        while (mem_bus.mem_req === 1'b1 && budget > 0) begin
            req_cycles++;
            if (mem_bus.mem_addr !== 8'h20 || mem_bus.mem_wdata !== 8'h77 ||
                mem_bus.mem_we !== 1'b1 || rf_we !== 1'b0 || mem_err !== 1'b0) begin
                stable = 1'b0;
            end
            budget--;
            step();
        end
        check("st_tmo_budget", 32'(budget > 0), 32'd1);
        check("st_req_cycles", 32'(req_cycles), 32'd15);
        check("st_stable",     32'(stable),     32'd1);
        check("st_mem_err",    32'(mem_err),    32'd1);
        check("st_tmo_no_wr",  32'(rf_we),      32'd0);
        check("st_tmo_ready",  32'(in_ready),   32'd1);
        step();
        check("st_err_end", 32'(mem_err), 32'd0);

        // ---- load r5 <- [0x30], ack exactly on the timeout cycle ----
        issue(4'b1001, 8'h30, 1'b0, 3'd5, 8'h00, 8'h00);
        for (int i = 1; i < 15; i++) step();
        check("ldt_req_c15", 32'(mem_bus.mem_req), 32'd1);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 8'h9C;
        step();
        mem_bus.mem_ack   = 1'b0;
        check("ldt_no_err", 32'(mem_err),  32'd0);
        check("ldt_rf_we",  32'(rf_we),    32'd1);
        check("ldt_waddr",  32'(rf_waddr), 32'd5);
        check("ldt_wdata",  32'(rf_wdata), 32'h9C);
        step();

        // ---- store acked in second cycle: straight back to idle ----
        issue(4'b1010, 8'h21, 1'b0, 3'd1, 8'h11, 8'h00);
        step();
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        check("st_ack_req",   32'(mem_bus.mem_req), 32'd0);
        check("st_ack_no_wr", 32'(rf_we),           32'd0);
        check("st_ack_ready", 32'(in_ready),        32'd1);
        check("st_ack_noerr", 32'(mem_err),         32'd0);

        // ---- ADD to r0 is suppressed, timing unchanged ----
        issue(4'b0000, 8'h99, 1'b0, 3'd0, 8'h00, 8'h00);
        check("r0_no_wr",   32'(rf_we),    32'd0);
        check("r0_ready",   32'(in_ready), 32'd0);
        step();
        check("r0_ready_hi", 32'(in_ready), 32'd1);

        // ---- NOP opcode ----
        issue(4'b1111, 8'hAB, 1'b1, 3'd4, 8'h00, 8'hCD);
        check("nop_no_wr",  32'(rf_we),           32'd0);
        check("nop_no_br",  32'(br_taken),        32'd0);
        check("nop_no_req", 32'(mem_bus.mem_req), 32'd0);
        check("nop_ready",  32'(in_ready),        32'd0);
        step();
        check("nop_ready_hi", 32'(in_ready), 32'd1);

`ifdef EXWB_FWD_EN
        // ---- forwarding copy of r5 = 0x33 ----
        issue(4'b0001, 8'h33, 1'b0, 3'd5, 8'h00, 8'h00);
        step();
        check("fwd_valid", 32'(fwd_valid), 32'd1);
        check("fwd_addr",  32'(fwd_addr),  32'd5);
        check("fwd_data",  32'(fwd_data),  32'h33);
`endif

        // ---- reset during MEM_WAIT ----
        issue(4'b1001, 8'h44, 1'b0, 3'd3, 8'h00, 8'h00);
        step();
        check("rstmw_req_before", 32'(mem_bus.mem_req), 32'd1);
        rst = 1'b1;
        step();
        check("rstmw_req",   32'(mem_bus.mem_req),  32'd0);
        check("rstmw_addr",  32'(mem_bus.mem_addr), 32'd0);
        check("rstmw_waddr", 32'(rf_waddr),         32'd0);
        check("rstmw_wdata", 32'(rf_wdata),         32'd0);
        check("rstmw_brtgt", 32'(br_target),        32'd0);
        check("rstmw_ready", 32'(in_ready),         32'd1);
        rst = 1'b0;
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        check("rstmw_no_wr", 32'(rf_we), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
